nrs_demap_buffer: RTL and testbench
===================================

# nrs_demap_buffer

Subframe buffer that sits between the FFT output and the channel estimator. It captures one NB-IoT subframe (12 subcarriers × 14 OFDM symbols) of complex samples and raises `demap_ready`. It then serves random-access reads addressed by column (symbol) and row (subcarrier) to the estimator's multiplier, and releases the subframe when the estimator acknowledges. It is the responder side of the `demap_ready` / `demap_read` / `col_demap` / `est_ack_demap` handshake.

## Interface
Parameters:
- `WIDTH_RX`, 16, bit width of each real/imag sample component
- `N_SC`, 12, subcarriers per symbol (rows)
- `N_SYM`, 14, symbols per subframe (columns)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `fft_valid`  in  1  input sample valid
- `fft_sof`  in  1  first sample of a subframe; qualified by `fft_valid`
- `fft_r`, `fft_i`  in  WIDTH_RX signed  input sample
- `demap_read`  in  1  read strobe from the estimator
- `col`  in  4  symbol index, 0..13
- `row`  in  4  subcarrier index, 0..11
- `est_ack_demap`  in  1  estimator has finished with the current subframe
- `demap_ready`  out  1  a complete subframe is available for reads
- `rx_r`, `rx_i`  out  WIDTH_RX signed  read data
- `rx_valid`  out  1  read data valid
- `overflow`  out  1  sticky: input sample dropped
- `addr_err`  out  1  sticky: read with out-of-range `col` or `row`

## Operation
- Storage: bank(s) of N_SC·N_SYM = 168 words, each 2·WIDTH_RX bits wide.
- Word address = `col`·N_SC + `row` (8 bits). Writes are subcarrier-fastest: write counter `wr_row` 0..11, then `wr_col` 0..13.
- Write FSM has two states, FILL and FULL per bank.
  - In FILL, each `fft_valid` writes one sample and advances the counter.
  - Write #168 marks the bank full and resets the counter to 0.
  - If `fft_sof` arrives with `fft_valid`, the counter restarts at address 0 and that sample is written there. Any partial subframe is discarded; `overflow` is not set.
- Full bank: `demap_ready` = 1 while the read bank is full.
- `est_ack_demap` while `demap_ready` = 1: the read bank is marked empty and `demap_ready` drops the next cycle. `est_ack_demap` while `demap_ready` = 0 is ignored.
- `fft_valid` while there is no writable bank: the sample is dropped and `overflow` is set. Fullness is judged on the current-cycle state, so an ack in the same cycle does not rescue that sample.
- Reads:
  - `demap_read` with `demap_ready` = 1: read data is returned the next cycle.
  - `col` > 13 or `row` > 11: returns zero with `rx_valid` = 1 and sets `addr_err`.
  - `demap_read` with `demap_ready` = 0: ignored; `rx_valid` = 0 and `rx_r` / `rx_i` hold their value.
- Reads and writes may occur in the same cycle; they always target different banks, or, in single-bank mode, a write cannot happen while the bank is full.

## Timing
- Reset values: `demap_ready` 0, `rx_valid` 0, `rx_r` / `rx_i` 0, `overflow` 0, `addr_err` 0. Reset also clears counters and all bank-full flags; it takes effect mid-fill or mid-read with no data recovery.
- Read latency is 1 cycle, with `rx_r` / `rx_i` / `rx_valid` registered. Back-to-back reads run at 1 per cycle.
- `demap_ready` rises 1 cycle after the cycle of write #168. It falls 1 cycle after an accepted ack, unless another full bank exists (see Configuration).
- Sticky flags clear only on `rst`.

## Configuration
- `DEMAP_PINGPONG_EN` defined:
  - Two banks; the write and read bank pointers toggle independently.
  - Filling continues into the other bank while the estimator reads.
  - If an ack and the other bank's 168th write occur in the same cycle, `demap_ready` stays 1 continuously and reads switch to the new bank the next cycle.
  - `overflow` occurs only when both banks are full.
- Not defined:
  - Single bank; all samples arriving while FULL are dropped with `overflow` set.
  - The bank returns to FILL the cycle after the ack.

## Structure
- Shared package `ch_est_pkg` holds:
  - `N_SC`, `N_SYM`, `N_RE` (168)
  - the address width (8)
  - the sample struct type `{r, i}`
- One sub-module, `demap_bank_ram`: a 168-deep simple dual-port synchronous RAM (1 write port, 1 registered read port), instantiated once or twice.
- Address calculation, FSM and flags live in the top module.

## Test plan
- Write 168 samples with value = address (`fft_r` = k, `fft_i` = −k), then read `col` = 3, `row` = 5 → next cycle `rx_r` = 41, `rx_i` = −41, `rx_valid` = 1; `demap_ready` rose 1 cycle after write #168.
- Full read sweep of all 168 addresses back-to-back → each result matches 1 cycle after its read; `addr_err` stays 0.
- Read `col` = 14 and then `row` = 12 → `rx_r` = `rx_i` = 0 with `rx_valid` = 1, and `addr_err` = 1 latched.
- Single bank: 168 writes, then 5 more samples before the ack → `overflow` = 1. After the ack, `demap_ready` = 0 and the next subframe fills from address 0.
- With `DEMAP_PINGPONG_EN`: stream 2 subframes continuously, reading the first and acking on the cycle of the second's write #168 → `demap_ready` never drops, reads return second-subframe data, and `overflow` = 0.
- Assert `fft_sof` at write #50, then assert `rst` mid-read → the subframe restarts at address 0 without `overflow`. After `rst`, all outputs are 0 and `demap_ready` = 0.

Source files
------------

// File: rtl/ch_est_pkg.sv
// Shared constants and types for the NRS channel-estimation datapath.
package ch_est_pkg;
    localparam int unsigned N_SC     = 12;
    localparam int unsigned N_SYM    = 14;
    localparam int unsigned N_RE     = N_SC * N_SYM;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned SAMPLE_W = 16;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] r;
        logic signed [SAMPLE_W-1:0] i;
    } sample_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } bank_state_t;
endpackage

// File: rtl/nrs_demap_buffer_if.sv
// FFT-side write stream and estimator-side demap read/ack handshake.
interface nrs_demap_buffer_if #(
    parameter int unsigned WIDTH_RX = ch_est_pkg::SAMPLE_W
);
    logic                       fft_valid;
    logic                       fft_sof;
    logic signed [WIDTH_RX-1:0] fft_r;
    logic signed [WIDTH_RX-1:0] fft_i;
    logic                       demap_read;
    logic [3:0]                 col;
    logic [3:0]                 row;
    logic                       est_ack_demap;
    logic                       demap_ready;
    logic signed [WIDTH_RX-1:0] rx_r;
    logic signed [WIDTH_RX-1:0] rx_i;
    logic                       rx_valid;
    logic                       overflow;
    logic                       addr_err;

    modport slave (
        input  fft_valid, fft_sof, fft_r, fft_i, demap_read, col, row, est_ack_demap,
        output demap_ready, rx_r, rx_i, rx_valid, overflow, addr_err
    );

    modport master (
        output fft_valid, fft_sof, fft_r, fft_i, demap_read, col, row, est_ack_demap,
        input  demap_ready, rx_r, rx_i, rx_valid, overflow, addr_err
    );
endinterface

// File: rtl/demap_bank_ram.sv
// Simple dual-port subframe RAM: one write port, one registered read port.
module demap_bank_ram #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 168,
    parameter int unsigned AW    = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/nrs_demap_buffer.sv
// Subframe capture buffer between FFT and channel estimator.
// Define DEMAP_PINGPONG_EN for two banks (fill one while the other is read).
module nrs_demap_buffer #(
    parameter int unsigned WIDTH_RX = 16,
    parameter int unsigned N_SC     = 12,
    parameter int unsigned N_SYM    = 14
) (
    input  logic              clk,
    input  logic              rst,
    nrs_demap_buffer_if.slave bus
);
    import ch_est_pkg::*;

`ifdef DEMAP_PINGPONG_EN
    localparam int unsigned NB       = 2;
    localparam bit          PINGPONG = 1'b1;
`else
    localparam int unsigned NB       = 1;
    localparam bit          PINGPONG = 1'b0;
`endif
    localparam int unsigned N_WORDS = N_SC * N_SYM;
    localparam int unsigned WORD_W  = 2 * WIDTH_RX;

    bank_state_t       state_q [NB];
    bank_state_t       state_d [NB];
    logic              wr_bank, rd_bank, rd_sel;
    logic [3:0]        wr_row, wr_col;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic              wr_en, wr_last, ack_accept, rd_accept, rd_in_range;
    logic              demap_ready_int, rx_valid_q, rd_zero, overflow_q, addr_err_q;
    logic [WORD_W-1:0] rdata [NB];

    assign demap_ready_int = (state_q[rd_bank] == FULL);

    always_comb begin
        wr_en       = bus.fft_valid && (state_q[wr_bank] == FILL);
        wr_addr     = bus.fft_sof ? '0 : ADDR_W'(wr_col * N_SC + wr_row);
        wr_last     = wr_en && !bus.fft_sof && (wr_addr == ADDR_W'(N_WORDS - 1));
        ack_accept  = bus.est_ack_demap && demap_ready_int;
        rd_accept   = bus.demap_read && demap_ready_int;
        rd_in_range = (bus.col < 4'(N_SYM)) && (bus.row < 4'(N_SC));
        rd_addr     = ADDR_W'(bus.col * N_SC + bus.row);
        // Write and ack never target the same bank: writes need FILL, acks need FULL.
        state_d = state_q;
        if (wr_last)    state_d[wr_bank] = FULL;
        if (ack_accept) state_d[rd_bank] = FILL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= '{default: FILL};
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            rd_sel     <= 1'b0;
            wr_row     <= '0;
            wr_col     <= '0;
            rx_valid_q <= 1'b0;
            rd_zero    <= 1'b1;
            overflow_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wr_en) begin
                if (wr_last) begin
                    wr_row <= '0;
                    wr_col <= '0;
                    if (PINGPONG) wr_bank <= ~wr_bank;
                end else if (bus.fft_sof) begin
                    wr_row <= 4'd1;
                    wr_col <= '0;
                end else if (wr_row == 4'(N_SC - 1)) begin
                    wr_row <= '0;
                    wr_col <= wr_col + 4'd1;
                end else begin
                    wr_row <= wr_row + 4'd1;
                end
            end
            if (bus.fft_valid && !wr_en) overflow_q <= 1'b1;
            if (ack_accept && PINGPONG) rd_bank <= ~rd_bank;
            rx_valid_q <= rd_accept;
            // rd_zero forces the output to zero for out-of-range reads and after reset.
            if (rd_accept) begin
                rd_zero <= !rd_in_range;
                rd_sel  <= rd_bank;
                if (!rd_in_range) addr_err_q <= 1'b1;
            end
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        demap_bank_ram #(
            .WIDTH (WORD_W),
            .DEPTH (N_WORDS),
            .AW    (ADDR_W)
        ) u_ram (
            .clk   (clk),
            .we    (wr_en && (wr_bank == 1'(b))),
            .waddr (wr_addr),
            .wdata ({bus.fft_r, bus.fft_i}),
            .re    (rd_accept && rd_in_range && (rd_bank == 1'(b))),
            .raddr (rd_addr),
            .rdata (rdata[b])
        );
    end

    assign bus.demap_ready = demap_ready_int;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.rx_r        = rd_zero ? '0 : rdata[rd_sel][WORD_W-1 -: WIDTH_RX];
    assign bus.rx_i        = rd_zero ? '0 : rdata[rd_sel][WIDTH_RX-1:0];
    assign bus.overflow    = overflow_q;
    assign bus.addr_err    = addr_err_q;
endmodule

// File: tb/tb_nrs_demap_buffer.sv
// Bench for nrs_demap_buffer: directed scenarios plus random traffic against a subframe-FIFO model.
module tb_nrs_demap_buffer;
    import ch_est_pkg::*;

`ifdef DEMAP_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    nrs_demap_buffer_if #(.WIDTH_RX(SAMPLE_W)) bus ();
    nrs_demap_buffer #(.WIDTH_RX(SAMPLE_W), .N_SC(N_SC), .N_SYM(N_SYM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: completed subframes are a FIFO of capacity NB; the partial one is a plain array.
    sample_t frames [2][N_RE];
    sample_t part [N_RE];
    int part_len, fcnt, fhead;
    logic e_ready, e_valid, e_ovf, e_aerr;
    logic signed [SAMPLE_W-1:0] e_r, e_i;

    task automatic model_reset();
        part_len = 0; fcnt = 0; fhead = 0;
        e_ready = 0; e_valid = 0; e_ovf = 0; e_aerr = 0; e_r = '0; e_i = '0;
    endtask

    task automatic cycle(input logic v, input logic sof, input logic signed [SAMPLE_W-1:0] r,
                         input logic signed [SAMPLE_W-1:0] i, input logic rd, input logic [3:0] c,
                         input logic [3:0] rw, input logic ack);
        int slot;
        bit done;
        bus.fft_valid = v; bus.fft_sof = sof; bus.fft_r = r; bus.fft_i = i;
        bus.demap_read = rd; bus.col = c; bus.row = rw; bus.est_ack_demap = ack;
        slot = (fhead + fcnt) % NB;
        done = 0;
        if (rd && fcnt > 0) begin
            e_valid = 1;
            if (c >= N_SYM || rw >= N_SC) begin
                e_r = '0; e_i = '0; e_aerr = 1;
            end else begin
                e_r = frames[fhead][c * N_SC + rw].r;
                e_i = frames[fhead][c * N_SC + rw].i;
            end
        end else begin
            e_valid = 0;
        end
        if (v) begin
            if (fcnt == NB) e_ovf = 1;
            else begin
                if (sof) part_len = 0;
                part[part_len].r = r;
                part[part_len].i = i;
                part_len++;
                if (part_len == N_RE) begin done = 1; part_len = 0; end
            end
        end
        if (ack && fcnt > 0) begin fhead = (fhead + 1) % NB; fcnt--; end
        if (done) begin frames[slot] = part; fcnt++; end
        e_ready = (fcnt > 0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, '0, '0, 0, 4'd0, 4'd0, 0);
    endtask

    task automatic do_reset();
        rst = 1;
        bus.fft_valid = 0; bus.fft_sof = 0; bus.fft_r = '0; bus.fft_i = '0;
        bus.demap_read = 0; bus.col = '0; bus.row = '0; bus.est_ack_demap = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.demap_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", bus.demap_ready); end
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.rx_valid); end
        checks++; if (bus.rx_r !== 16'sd0) begin errors++; $display("FAIL rst_rx_r got %0d want 0", bus.rx_r); end
        checks++; if (bus.rx_i !== 16'sd0) begin errors++; $display("FAIL rst_rx_i got %0d want 0", bus.rx_i); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b want 0", bus.overflow); end
        checks++; if (bus.addr_err !== 1'b0) begin errors++; $display("FAIL rst_addr_err got %b want 0", bus.addr_err); end
    endtask

    task automatic test_fill_and_read();
        for (int k = 0; k < N_RE; k++) begin
            cycle(1, k == 0, 16'(k), 16'(-k), 0, 4'd0, 4'd0, 0);
            if (k == N_RE - 2) begin
                checks++; if (bus.demap_ready !== 1'b0) begin errors++; $display("FAIL ready_early got %b want 0", bus.demap_ready); end
            end
        end
        checks++; if (bus.demap_ready !== 1'b1) begin errors++; $display("FAIL ready_rise got %b want 1", bus.demap_ready); end
        cycle(0, 0, '0, '0, 1, 4'd3, 4'd5, 0);
        checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL read35_valid got %b want 1", bus.rx_valid); end
        checks++; if (bus.rx_r !== 16'sd41) begin errors++; $display("FAIL read35_r got %0d want 41", bus.rx_r); end
        checks++; if (bus.rx_i !== -16'sd41) begin errors++; $display("FAIL read35_i got %0d want -41", bus.rx_i); end
        idle();
        checks++; if (bus.rx_valid !== 1'b0 || bus.rx_r !== 16'sd41) begin
            errors++; $display("FAIL read_hold valid %b r %0d want valid 0 r 41", bus.rx_valid, bus.rx_r);
        end
    endtask

    task automatic test_sweep();
        for (int a = 0; a < N_RE; a++) begin
            cycle(0, 0, '0, '0, 1, 4'(a / N_SC), 4'(a % N_SC), 0);
            checks++; if (bus.rx_valid !== 1'b1 || bus.rx_r !== e_r || bus.rx_i !== e_i) begin
                errors++; $display("FAIL sweep addr %0d got v%b %0d/%0d want v1 %0d/%0d", a, bus.rx_valid, bus.rx_r, bus.rx_i, e_r, e_i);
            end
        end
        idle();
        checks++; if (bus.addr_err !== 1'b0) begin errors++; $display("FAIL sweep_addr_err got %b want 0", bus.addr_err); end
    endtask

    task automatic test_addr_err();
        cycle(0, 0, '0, '0, 1, 4'd14, 4'd0, 0);
        checks++; if (bus.rx_valid !== 1'b1 || bus.rx_r !== 16'sd0 || bus.rx_i !== 16'sd0 || bus.addr_err !== 1'b1) begin
            errors++; $display("FAIL col14 got v%b %0d/%0d err %b want v1 0/0 err 1", bus.rx_valid, bus.rx_r, bus.rx_i, bus.addr_err);
        end
        cycle(0, 0, '0, '0, 1, 4'd2, 4'd2, 0);
        checks++; if (bus.rx_r !== e_r) begin errors++; $display("FAIL read22 got %0d want %0d", bus.rx_r, e_r); end
        cycle(0, 0, '0, '0, 1, 4'd0, 4'd12, 0);
        checks++; if (bus.rx_valid !== 1'b1 || bus.rx_r !== 16'sd0 || bus.rx_i !== 16'sd0 || bus.addr_err !== 1'b1) begin
            errors++; $display("FAIL row12 got v%b %0d/%0d err %b want v1 0/0 err 1", bus.rx_valid, bus.rx_r, bus.rx_i, bus.addr_err);
        end
    endtask

`ifndef DEMAP_PINGPONG_EN
    task automatic test_overflow();
        for (int k = 0; k < 5; k++) cycle(1, 0, 16'($urandom), 16'($urandom), 0, 4'd0, 4'd0, 0);
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL overflow got %b want 1", bus.overflow); end
        checks++; if (bus.demap_ready !== 1'b1) begin errors++; $display("FAIL ready_hold got %b want 1", bus.demap_ready); end
        cycle(1, 0, 16'sd999, 16'sd999, 0, 4'd0, 4'd0, 1);
        checks++; if (bus.demap_ready !== 1'b0) begin errors++; $display("FAIL ack_drop got %b want 0", bus.demap_ready); end
        cycle(0, 0, '0, '0, 1, 4'd1, 4'd1, 0);
        checks++; if (bus.rx_valid !== 1'b0 || bus.rx_r !== e_r) begin
            errors++; $display("FAIL read_unready got v%b r %0d want v0 r %0d", bus.rx_valid, bus.rx_r, e_r);
        end
        for (int k = 0; k < N_RE; k++) cycle(1, 0, 16'($urandom), 16'($urandom), 0, 4'd0, 4'd0, 0);
        checks++; if (bus.demap_ready !== 1'b1) begin errors++; $display("FAIL refill_ready got %b want 1", bus.demap_ready); end
        for (int k = 0; k < 24; k++) begin
            if (k == 0) cycle(0, 0, '0, '0, 1, 4'd0, 4'd0, 0);
            else cycle(0, 0, '0, '0, 1, 4'($urandom_range(0, 13)), 4'($urandom_range(0, 11)), 0);
            checks++; if (bus.rx_r !== e_r || bus.rx_i !== e_i) begin
                errors++; $display("FAIL refill_read %0d got %0d/%0d want %0d/%0d", k, bus.rx_r, bus.rx_i, e_r, e_i);
            end
        end
    endtask
`else
    task automatic test_pingpong();
        do_reset();
        for (int k = 0; k < 2 * N_RE; k++) begin
            cycle(1, k == 0, 16'($urandom), 16'($urandom), k >= N_RE,
                  4'(($urandom_range(0, 167)) / N_SC), 4'($urandom_range(0, 11)), k == 2 * N_RE - 1);
            if (k >= N_RE) begin
                checks++; if (bus.demap_ready !== 1'b1 || bus.rx_r !== e_r || bus.rx_i !== e_i) begin
                    errors++; $display("FAIL pp_stream %0d ready %b got %0d/%0d want %0d/%0d", k, bus.demap_ready, bus.rx_r, bus.rx_i, e_r, e_i);
                end
            end
        end
        for (int k = 0; k < 20; k++) begin
            cycle(0, 0, '0, '0, 1, 4'($urandom_range(0, 13)), 4'($urandom_range(0, 11)), 0);
            checks++; if (bus.demap_ready !== 1'b1 || bus.rx_r !== e_r || bus.rx_i !== e_i) begin
                errors++; $display("FAIL pp_second %0d ready %b got %0d/%0d want %0d/%0d", k, bus.demap_ready, bus.rx_r, bus.rx_i, e_r, e_i);
            end
        end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL pp_overflow got %b want 0", bus.overflow); end
    endtask
`endif

    task automatic test_sof_rst();
        logic signed [SAMPLE_W-1:0] first_r;
        do_reset();
        first_r = '0;
        for (int k = 0; k < 49 + N_RE; k++) begin
            logic signed [SAMPLE_W-1:0] r;
            r = 16'($urandom);
            if (k == 49) first_r = r;
            cycle(1, k == 49, r, 16'($urandom), 0, 4'd0, 4'd0, 0);
            if (k == N_RE - 1) begin
                checks++; if (bus.demap_ready !== 1'b0) begin errors++; $display("FAIL sof_discard got %b want 0", bus.demap_ready); end
            end
        end
        checks++; if (bus.demap_ready !== 1'b1 || bus.overflow !== 1'b0) begin
            errors++; $display("FAIL sof_complete ready %b ovf %b want 1 0", bus.demap_ready, bus.overflow);
        end
        cycle(0, 0, '0, '0, 1, 4'd0, 4'd0, 0);
        checks++; if (bus.rx_r !== first_r) begin errors++; $display("FAIL sof_addr0 got %0d want %0d", bus.rx_r, first_r); end
        cycle(0, 0, '0, '0, 1, 4'd9, 4'd7, 0);
        checks++; if (bus.rx_r !== e_r || bus.rx_i !== e_i) begin
            errors++; $display("FAIL sof_read got %0d/%0d want %0d/%0d", bus.rx_r, bus.rx_i, e_r, e_i);
        end
        rst = 1;
        bus.demap_read = 1; bus.col = 4'd3; bus.row = 4'd5;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        bus.demap_read = 0;
        checks++; if (bus.demap_ready !== 1'b0 || bus.rx_valid !== 1'b0 || bus.rx_r !== 16'sd0 || bus.rx_i !== 16'sd0
                      || bus.overflow !== 1'b0 || bus.addr_err !== 1'b0) begin
            errors++; $display("FAIL midread_rst ready %b v %b %0d/%0d ovf %b err %b want all 0",
                               bus.demap_ready, bus.rx_valid, bus.rx_r, bus.rx_i, bus.overflow, bus.addr_err);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] c, rw;
            c  = ($urandom_range(0, 31) == 0) ? 4'($urandom_range(14, 15)) : 4'($urandom_range(0, 13));
            rw = ($urandom_range(0, 31) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
            cycle($urandom_range(0, 9) < 8, $urandom_range(0, 499) == 0, 16'($urandom), 16'($urandom),
                  1'($urandom), c, rw, (fcnt > 0) && ($urandom_range(0, 99) < 3));
            checks++; if (bus.demap_ready !== e_ready) begin errors++; $display("FAIL rnd_ready %0d got %b want %b", n, bus.demap_ready, e_ready); end
            checks++; if (bus.rx_valid !== e_valid) begin errors++; $display("FAIL rnd_valid %0d got %b want %b", n, bus.rx_valid, e_valid); end
            checks++; if (bus.rx_r !== e_r) begin errors++; $display("FAIL rnd_rx_r %0d got %0d want %0d", n, bus.rx_r, e_r); end
            checks++; if (bus.rx_i !== e_i) begin errors++; $display("FAIL rnd_rx_i %0d got %0d want %0d", n, bus.rx_i, e_i); end
            checks++; if (bus.overflow !== e_ovf) begin errors++; $display("FAIL rnd_overflow %0d got %b want %b", n, bus.overflow, e_ovf); end
            checks++; if (bus.addr_err !== e_aerr) begin errors++; $display("FAIL rnd_addr_err %0d got %b want %b", n, bus.addr_err, e_aerr); end
        end
    endtask

    initial begin
        test_reset();
        test_fill_and_read();
        test_sweep();
        test_addr_err();
`ifndef DEMAP_PINGPONG_EN
        test_overflow();
`else
        test_pingpong();
`endif
        test_sof_rst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
